// File: rtl/tuple_extractor.sv
// Tuple extractor: parses an IPv4 header stream, captures the TCP/UDP 5-tuple fields and
// emits them to the NAT stage as four 32-bit words. Packets that cannot yield a tuple
// (bad version/IHL, fragments, other protocols, truncation) are discarded and counted.
module tuple_extractor #(
  parameter int unsigned DROP_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pkt_valid_i,
  input  logic [31:0]           pkt_data_i,
  input  logic                  pkt_last_i,
  output logic                  pkt_ready_o,
  output logic                  tuple_valid_o,
  output logic [31:0]           tuple_data_o,
  input  logic                  tuple_ready_i,
  output logic [DROP_CNT_W-1:0] drop_count_o
);

  typedef enum logic [2:0] {
    S_HDR0,   // waiting for header word 0
    S_HDR,    // header words 1..IHL-1
    S_PORT,   // port word at index IHL
    S_EMIT,   // sending the 4-word tuple
    S_DRAIN   // discarding the rest of the packet
  } state_e;

  state_e r_state;
  state_e w_state_next;

  // Header parsing state
  logic [3:0]  r_idx;        // index of the word currently expected in S_HDR
  logic [3:0]  r_ihl;
  logic [7:0]  r_proto;
  logic [31:0] r_src_ip;
  logic [31:0] r_dst_ip;
  logic [31:0] r_ports;      // already in output order {dst_port, src_port}
  logic        r_port_last;  // port word closed the packet

  // Tuple output state
  logic [1:0]  r_emit_idx;
  logic        r_tuple_valid;
  logic [31:0] r_tuple_data;

  logic [DROP_CNT_W-1:0] r_drop_cnt;

  // Decoded handshakes and checks
  logic w_pkt_ready;
  logic w_pkt_acc;
  logic w_tup_acc;
  logic w_hdr0_bad;
  logic w_frag_bad;
  logic w_proto_bad;
  logic w_hdr_bad;
  logic w_hdr_end;
  logic w_drop;
  logic w_emit_start;
  logic w_emit_done;

  assign w_pkt_ready = (r_state != S_EMIT);
  assign w_pkt_acc   = pkt_valid_i && w_pkt_ready;
  assign w_tup_acc   = r_tuple_valid && tuple_ready_i;

  // Word 0: version must be 4 and the header at least 5 words long.
  assign w_hdr0_bad  = (pkt_data_i[31:28] != 4'd4) || (pkt_data_i[27:24] < 4'd5);
  // Word 1: any non-zero fragment offset means no L4 header in this packet.
  assign w_frag_bad  = (r_idx == 4'd1) && (pkt_data_i[12:0] != 13'd0);
  // Word 2: only TCP (6) and UDP (17) carry the port word we need.
  assign w_proto_bad = (r_idx == 4'd2) &&
                       !((pkt_data_i[23:16] == 8'd6) || (pkt_data_i[23:16] == 8'd17));
  assign w_hdr_bad   = w_frag_bad || w_proto_bad;
  // IHL is at least 5 here, so IHL-1 never underflows.
  assign w_hdr_end   = (r_idx == (r_ihl - 4'd1));
  assign w_emit_done = w_tup_acc && (r_emit_idx == 2'd3);

  // Next-state decode plus drop/emit event strobes.
  always_comb begin
    w_state_next = r_state;
    w_drop       = 1'b0;
    w_emit_start = 1'b0;
    unique case (r_state)
      S_HDR0: begin
        if (w_pkt_acc) begin
          if (w_hdr0_bad || pkt_last_i) begin
            // A bad header or a one-word packet both count as a single drop.
            w_drop       = 1'b1;
            w_state_next = pkt_last_i ? S_HDR0 : S_DRAIN;
          end else begin
            w_state_next = S_HDR;
          end
        end
      end
      S_HDR: begin
        if (w_pkt_acc) begin
          if (w_hdr_bad || pkt_last_i) begin
            // Truncation before the port word is a drop even if the checks passed.
            w_drop       = 1'b1;
            w_state_next = pkt_last_i ? S_HDR0 : S_DRAIN;
          end else if (w_hdr_end) begin
            w_state_next = S_PORT;
          end
        end
      end
      S_PORT: begin
        if (w_pkt_acc) begin
          w_emit_start = 1'b1;
          w_state_next = S_EMIT;
        end
      end
      S_EMIT: begin
        if (w_emit_done) begin
          w_state_next = r_port_last ? S_HDR0 : S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_pkt_acc && pkt_last_i) begin
          w_state_next = S_HDR0;
        end
      end
      default: begin
        w_state_next = S_HDR0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_HDR0;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Header field capture; options and payload words are accepted without being stored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx       <= 4'd0;
      r_ihl       <= 4'd0;
      r_proto     <= 8'd0;
      r_src_ip    <= 32'd0;
      r_dst_ip    <= 32'd0;
      r_ports     <= 32'd0;
      r_port_last <= 1'b0;
    end else if (w_pkt_acc) begin
      if (r_state == S_HDR0) begin
        r_ihl <= pkt_data_i[27:24];
        r_idx <= 4'd1;
      end
      if (r_state == S_HDR) begin
        // Leaves S_HDR at index IHL-1 <= 14, so the 4-bit index never wraps.
        r_idx <= r_idx + 4'd1;
        if (r_idx == 4'd2) r_proto  <= pkt_data_i[23:16];
        if (r_idx == 4'd3) r_src_ip <= pkt_data_i;
        if (r_idx == 4'd4) r_dst_ip <= pkt_data_i;
      end
      if (r_state == S_PORT) begin
        r_ports     <= {pkt_data_i[15:0], pkt_data_i[31:16]};
        r_port_last <= pkt_last_i;
      end
    end
  end

  // Tuple sequencer: loads src_ip on the port beat, then steps on each accepted word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tuple_valid <= 1'b0;
      r_tuple_data  <= 32'd0;
      r_emit_idx    <= 2'd0;
    end else if (w_emit_start) begin
      r_tuple_valid <= 1'b1;
      r_tuple_data  <= r_src_ip;
      r_emit_idx    <= 2'd0;
    end else if (w_tup_acc) begin
      r_emit_idx <= r_emit_idx + 2'd1;
      unique case (r_emit_idx)
        2'd0: r_tuple_data <= r_dst_ip;
        2'd1: r_tuple_data <= r_ports;
        2'd2: r_tuple_data <= {24'd0, r_proto};
        2'd3: begin
          r_tuple_valid <= 1'b0;
          r_tuple_data  <= 32'd0;
        end
        default: r_tuple_data <= 32'd0;
      endcase
    end
  end

  // Saturating drop counter, one increment per discarded packet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != {DROP_CNT_W{1'b1}})) begin
      r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
    end
  end

  assign pkt_ready_o   = w_pkt_ready && !rst;
  assign tuple_valid_o = r_tuple_valid;
  assign tuple_data_o  = r_tuple_data;
  assign drop_count_o  = r_drop_cnt;

endmodule

// File: tb/tb_tuple_extractor.sv
// Bench for tuple_extractor: directed and random IPv4 packets, tuples checked against a
// packet-level reference model; a second instance with a 2-bit drop counter checks saturation.
module tb_tuple_extractor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pkt_valid_i = 1'b0;
  logic [31:0] pkt_data_i = 32'd0;
  logic        pkt_last_i = 1'b0;
  logic        tuple_ready_i = 1'b1;
  logic        pkt_ready_o;
  logic        tuple_valid_o;
  logic [31:0] tuple_data_o;
  logic [15:0] drop_count_o;
  logic        sat_pkt_ready;
  logic        sat_tuple_valid;
  logic [31:0] sat_tuple_data;
  logic [1:0]  sat_drop_count;

  always #5 clk = ~clk;

  tuple_extractor #(.DROP_CNT_W(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .pkt_valid_i   (pkt_valid_i),
    .pkt_data_i    (pkt_data_i),
    .pkt_last_i    (pkt_last_i),
    .pkt_ready_o   (pkt_ready_o),
    .tuple_valid_o (tuple_valid_o),
    .tuple_data_o  (tuple_data_o),
    .tuple_ready_i (tuple_ready_i),
    .drop_count_o  (drop_count_o)
  );

  tuple_extractor #(.DROP_CNT_W(2)) dut_sat (
    .clk           (clk),
    .rst           (rst),
    .pkt_valid_i   (pkt_valid_i),
    .pkt_data_i    (pkt_data_i),
    .pkt_last_i    (pkt_last_i),
    .pkt_ready_o   (sat_pkt_ready),
    .tuple_valid_o (sat_tuple_valid),
    .tuple_data_o  (sat_tuple_data),
    .tuple_ready_i (tuple_ready_i),
    .drop_count_o  (sat_drop_count)
  );

  int total = 0;
  int bad = 0;
  int exp_drops = 0;
  logic [31:0] pw[$];     // packet being built
  logic [31:0] exp_q[$];  // expected tuple words
  logic [31:0] obs_q[$];  // tuple words seen leaving the DUT

  int rdy_mode = 0;       // 0: always ready, 1: random, 2: 5-cycle stall after stall_at words
  int stall_at = 0;
  int stall_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // Monitor: collects tuple beats, checks hold-under-backpressure, times pkt_ready_o low runs.
  logic        pv = 1'b0;
  logic        pr = 1'b0;
  logic [31:0] pd = 32'd0;
  int run_lo = 0;
  int last_run = 0;
  int stall_seen = 0;
  always @(negedge clk) begin
    if (rst) begin
      pv <= 1'b0;
      run_lo <= 0;
    end else begin
      if (pv && !pr) begin
        chk("hold_valid", 32'(tuple_valid_o), 32'd1);
        chk("hold_data", tuple_data_o, pd);
      end
      if (tuple_valid_o && tuple_ready_i) obs_q.push_back(tuple_data_o);
      if (tuple_valid_o && !tuple_ready_i) stall_seen <= stall_seen + 1;
      pv <= tuple_valid_o;
      pr <= tuple_ready_i;
      pd <= tuple_data_o;
      if (!pkt_ready_o) begin
        run_lo <= run_lo + 1;
      end else if (run_lo > 0) begin
        last_run <= run_lo;
        run_lo <= 0;
      end
    end
  end

  // Tuple-side ready generator.
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 1) begin
      tuple_ready_i <= 1'($urandom_range(0, 1));
    end else if (rdy_mode == 2 && obs_q.size() >= stall_at && stall_cnt < 5) begin
      tuple_ready_i <= 1'b0;
      stall_cnt <= stall_cnt + 1;
    end else begin
      tuple_ready_i <= 1'b1;
      if (rdy_mode != 2) stall_cnt <= 0;
    end
  end

  // Reference model: decides the fate of the whole packet in pw.
  task automatic model_pkt();
    int n;
    logic [3:0] ihl;
    logic [7:0] proto;
    bit drop;
    n = pw.size();
    ihl = pw[0][27:24];
    drop = (pw[0][31:28] != 4'd4) || (ihl < 4'd5) || (n <= int'(ihl));
    if (!drop) begin
      proto = pw[2][23:16];
      drop = (pw[1][12:0] != 13'd0) || !(proto == 8'd6 || proto == 8'd17);
    end
    if (drop) begin
      exp_drops++;
    end else begin
      exp_q.push_back(pw[3]);
      exp_q.push_back(pw[4]);
      exp_q.push_back({pw[ihl][15:0], pw[ihl][31:16]});
      exp_q.push_back({24'd0, pw[2][23:16]});
    end
  endtask

  task automatic send_word(input logic [31:0] w, input logic l);
    int n = 0;
    pkt_valid_i = 1'b1;
    pkt_data_i = w;
    pkt_last_i = l;
    forever begin
      @(negedge clk);
      if (pkt_ready_o) break;
      n++;
      if (n > 1000) begin
        $display("FAIL send_timeout observed=pkt_ready_o_low expected=ready_within_1000");
        $fatal(1, "pkt_ready_o stuck low");
      end
    end
    @(posedge clk);
    #1;
    pkt_valid_i = 1'b0;
    pkt_last_i = 1'b0;
  endtask

  task automatic send_pkt(input int gap);
    model_pkt();
    for (int i = 0; i < pw.size(); i++) begin
      if (gap > 0) repeat ($urandom_range(0, gap)) begin @(posedge clk); #1; end
      send_word(pw[i], 1'(i == pw.size() - 1));
    end
    pw.delete();
  endtask

  task automatic flush(input string tag);
    int n = 0;
    int sat_exp;
    while (obs_q.size() < exp_q.size() && n < 500) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && obs_q.size() > 0) chk(tag, obs_q.pop_front(), exp_q.pop_front());
    obs_q.delete();
    exp_q.delete();
    sat_exp = (exp_drops > 3) ? 3 : exp_drops;
    chk({tag, "_drops"}, 32'(drop_count_o), 32'(exp_drops));
    chk({tag, "_sat_drops"}, 32'(sat_drop_count), 32'(sat_exp));
  endtask

  task automatic build_min();
    pw = '{32'h45000028, 32'h00000000, 32'h40060000, 32'hC0A80001, 32'h0A000001,
           32'h1F900050};
  endtask

  task automatic build_rand();
    int kind;
    int len;
    logic [3:0] ihl;
    logic [3:0] v;
    logic [7:0] p;
    logic [31:0] w;
    kind = $urandom_range(0, 9);
    ihl = 4'($urandom_range(5, 8));
    w = $urandom;
    pw.push_back({4'd4, ihl, w[23:0]});
    w = $urandom;
    pw.push_back({w[31:13], 13'd0});
    w = $urandom;
    pw.push_back({w[31:24], ($urandom_range(0, 1) == 1) ? 8'd17 : 8'd6, w[15:0]});
    for (int i = 3; i <= int'(ihl); i++) pw.push_back($urandom);
    repeat ($urandom_range(0, 3)) pw.push_back($urandom);
    w = pw[0];
    case (kind)
      5: begin
        do v = 4'($urandom); while (v == 4'd4);
        pw[0] = {v, w[27:0]};
      end
      6: pw[0] = {4'd4, 4'($urandom_range(0, 4)), w[23:0]};
      7: begin
        w = pw[1];
        pw[1] = {w[31:13], 13'($urandom_range(1, 8191))};
      end
      8: begin
        do p = 8'($urandom); while (p == 8'd6 || p == 8'd17);
        w = pw[2];
        pw[2] = {w[31:24], p, w[15:0]};
      end
      9: begin
        len = $urandom_range(1, int'(ihl));
        while (pw.size() > len) void'(pw.pop_back());
      end
      default: ;
    endcase
  endtask

  initial begin
    int base;
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pkt_ready", 32'(pkt_ready_o), 32'd0);
    chk("rst_tuple_valid", 32'(tuple_valid_o), 32'd0);
    chk("rst_tuple_data", tuple_data_o, 32'd0);
    chk("rst_drops", 32'(drop_count_o), 32'd0);
    chk("rst_sat_data", sat_tuple_data, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_pkt_ready", 32'(pkt_ready_o), 32'd1);
    chk("idle_sat_valid", 32'(sat_tuple_valid), 32'd0);

    // Minimal TCP packet
    build_min();
    send_pkt(0);
    flush("min");

    // IHL=6 with one option word and three payload words, then a minimal packet
    pw = '{32'h46000028, 32'h00000000, 32'h40060000, 32'hC0A80001, 32'h0A000001,
           32'h01020304, 32'h1F900050, 32'hDEADBEEF, 32'h11111111, 32'h22222222};
    send_pkt(0);
    chk("emit_ready_low_cycles", 32'(last_run), 32'd4);
    build_min();
    send_pkt(0);
    flush("opt");

    // Five-cycle stall after the second tuple word
    base = stall_seen;
    stall_at = 2;
    rdy_mode = 2;
    build_min();
    send_pkt(0);
    flush("bp");
    chk("bp_stall_cycles", 32'(stall_seen - base), 32'd5);
    rdy_mode = 0;

    // Random packets with random tuple backpressure and input gaps
    rdy_mode = 1;
    for (int k = 0; k < 40; k++) begin
      build_rand();
      send_pkt(2);
      flush("rand");
    end
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;

    // Rejects from a clean counter: ICMP, version 6, fragment, truncated at word 3
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_drops = 0;
    build_min(); pw[2] = 32'h40010000; send_pkt(0);
    build_min(); pw[0] = 32'h65000028; send_pkt(0);
    build_min(); pw[1] = 32'h00000001; send_pkt(0);
    build_min(); while (pw.size() > 4) void'(pw.pop_back()); send_pkt(0);
    flush("rej");
    // Fifth bad packet (IHL=4): 2-bit counter stays saturated
    build_min(); pw[0] = 32'h44000028; send_pkt(0);
    flush("sat");

    // Reset in the middle of tuple emission
    build_min();
    for (int i = 0; i < pw.size(); i++) send_word(pw[i], 1'(i == pw.size() - 1));
    pw.delete();
    n = 0;
    while (obs_q.size() < 2 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_tuple_valid", 32'(tuple_valid_o), 32'd0);
    chk("mid_rst_tuple_data", tuple_data_o, 32'd0);
    chk("mid_rst_pkt_ready", 32'(pkt_ready_o), 32'd0);
    chk("mid_rst_drops", 32'(drop_count_o), 32'd0);
    chk("mid_rst_words", 32'(obs_q.size()), 32'd2);
    if (obs_q.size() >= 2) begin
      chk("mid_rst_w0", obs_q[0], 32'hC0A80001);
      chk("mid_rst_w1", obs_q[1], 32'h0A000001);
    end
    obs_q.delete();
    exp_drops = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    build_min();
    send_pkt(0);
    flush("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tuple_extractor.md
TUPLE_EXTRACTOR -- requirements
Module: tuple_extractor

Interface
REQ-001 The block SHALL have parameter DROP_CNT_W, default 16, giving the width of the dropped-packet counter.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port pkt_valid_i, input, 1 bit: the upstream packet word is valid.
REQ-005 The block SHALL have port pkt_data_i, input, 32 bits: IPv4 packet word, big-endian, with word 0 being the first IP header word.
REQ-006 The block SHALL have port pkt_last_i, input, 1 bit: the current word is the final word of the packet.
REQ-007 The block SHALL have port pkt_ready_o, output, 1 bit: the block accepts a packet word this cycle.
REQ-008 The block SHALL have port tuple_valid_o, output, 1 bit: a tuple word is offered to the NAT stage.
REQ-009 The block SHALL have port tuple_data_o, output, 32 bits: the tuple word.
REQ-010 The block SHALL have port tuple_ready_i, input, 1 bit: the NAT stage accepts the tuple word.
REQ-011 The block SHALL have port drop_count_o, output, DROP_CNT_W bits: count of discarded packets.

Function
REQ-012 A word transfer SHALL occur only on a cycle where the corresponding valid and ready are both 1; a beat is "accepted" on that cycle.
REQ-013 The FSM SHALL have exactly five states.
- S_HDR0: waiting for word 0.
- S_HDR: words 1..IHL-1.
- S_PORT: port word at index IHL.
- S_EMIT: emitting the 4-word tuple.
- S_DRAIN: discarding the remainder of the packet.
REQ-014 pkt_ready_o SHALL be 1 in S_HDR0, S_HDR, S_PORT and S_DRAIN, and 0 in S_EMIT and while rst is high.
REQ-015 The word 0 check SHALL capture IHL = [27:24]; the packet SHALL be dropped if version [31:28] != 4 or IHL < 5; otherwise the FSM SHALL go to S_HDR.
REQ-016 The word 1 check SHALL drop the packet if the fragment offset [12:0] != 0.
REQ-017 The word 2 check SHALL capture protocol = [23:16]; the packet SHALL be dropped unless protocol is 6 or 17.
REQ-018 Word 3 SHALL be captured as src_ip and word 4 as dst_ip; words 5..IHL-1 (options) SHALL be discarded; the FSM SHALL go to S_PORT after word IHL-1.
REQ-019 The word at index IHL SHALL supply src_port = [31:16] and dst_port = [15:0]; on its acceptance the FSM SHALL go to S_EMIT.
REQ-020 In S_EMIT the block SHALL send, in order, src_ip, dst_ip, {dst_port, src_port}, {24'b0, protocol}.
REQ-021 tuple_valid_o SHALL rise on the cycle after the port word is accepted (1-cycle latency); tuple_data_o SHALL be a register output.
REQ-022 While tuple_valid_o=1 and tuple_ready_i=0, tuple_data_o SHALL hold stable.
REQ-023 With tuple_ready_i held at 1, the 4 words SHALL go out on 4 consecutive cycles.
REQ-024 After the 4th word is accepted, the FSM SHALL go to S_HDR0 if the port word had pkt_last_i=1; otherwise it SHALL go to S_DRAIN.
REQ-025 S_DRAIN SHALL accept and discard words until a beat with pkt_last_i=1 is accepted, then go to S_HDR0.
REQ-026 On a drop decision, drop_count_o SHALL increment by exactly 1 per packet.
- The FSM SHALL go to S_DRAIN, or to S_HDR0 if that word had pkt_last_i=1.
- No tuple word SHALL be emitted for a dropped packet.
REQ-027 Truncation: pkt_last_i=1 accepted on any word index < IHL SHALL count as a drop, and the FSM SHALL go to S_HDR0.
REQ-028 drop_count_o SHALL saturate at all-ones and SHALL NOT wrap.
REQ-029 The header word counter SHALL be 4 bits wide and SHALL cover indices 0..15 without wrap.
REQ-030 Words beyond the port word SHALL never affect the tuple.
REQ-031 Packets SHALL be processed strictly in arrival order; no tuple SHALL be reordered or duplicated.

Reset
REQ-032 Asserting rst SHALL asynchronously set the following, regardless of state:
- state to S_HDR0;
- tuple_valid_o=0, tuple_data_o=0, drop_count_o=0;
- pkt_ready_o=0 while rst is high;
- all captured fields to 0.
REQ-033 A reset during S_EMIT or S_DRAIN SHALL abandon the partial tuple or packet.
REQ-034 After rst deasserts, the next accepted word SHALL be treated as word 0.

Verification
REQ-035 Minimal packet: words 0x45000028, 0x00000000, 0x40060000, 0xC0A80001, 0x0A000001, 0x1F900050 (last) -> tuple 0xC0A80001, 0x0A000001, 0x00501F90, 0x00000006; drop_count_o stays 0.
REQ-036 Options and trailing payload: same packet with IHL=6, one option word, and 3 payload words with pkt_last_i on the final one -> identical tuple; pkt_ready_o=0 for exactly 4 cycles with tuple_ready_i=1; the next packet is parsed correctly.
REQ-037 Backpressure: tuple_ready_i=0 for 5 cycles mid-tuple -> tuple_data_o stable, no word lost or repeated.
REQ-038 Rejects: protocol 1 (ICMP), version 6, fragment offset 1, and a packet ending at word 3 -> no tuple_valid_o pulse; drop_count_o = 4.
REQ-039 Saturation: DROP_CNT_W=2 with 5 bad packets -> drop_count_o = 3.
REQ-040 Reset during S_EMIT after 2 tuple words -> tuple_valid_o=0 immediately; a following valid packet yields a full, correct 4-word tuple.
